// File: rtl/hwr_cls_pkg.sv
// hwr_cls_pkg: shared defaults, result record and score comparison for the argmax back-end
package hwr_cls_pkg;
   localparam int N_CLASSES_DEF = 10;
   localparam int DATA_W_DEF    = 12;
   localparam int IDX_W_DEF     = $clog2(N_CLASSES_DEF);
   // Scores are widened to this width before comparing so one function serves every DATA_W
   localparam int CMP_W         = 64;
   typedef struct packed {
      logic [IDX_W_DEF-1:0]  best_idx;
      logic [IDX_W_DEF-1:0]  second_idx;
      logic [DATA_W_DEF-1:0] best_val;
      logic [DATA_W_DEF-1:0] margin;
      logic                  low_conf;
      logic                  frame_err;
   } result_t;
   function automatic logic score_gt(input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b,
                                     input logic signed_mode);
      return signed_mode ? ($signed(a) > $signed(b)) : (a > b);
   endfunction
endpackage

// File: rtl/classifier_argmax_top2_tracker.sv
// top2_tracker: combinational next best/second update for one incoming score
// Ports: i_score/i_idx incoming score and its class; i_first marks element 0;
//        i_best*/i_second*/i_sec_empty current tracker state; o_* updated tracker state
module top2_tracker import hwr_cls_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF,
   parameter bit SIGNED = 1'b0
) (
   input  logic [DATA_W-1:0] i_score,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic              i_first,
   input  logic [DATA_W-1:0] i_best,
   input  logic [IDX_W-1:0]  i_best_idx,
   input  logic [DATA_W-1:0] i_second,
   input  logic [IDX_W-1:0]  i_second_idx,
   input  logic              i_sec_empty,
   output logic [DATA_W-1:0] o_best,
   output logic [IDX_W-1:0]  o_best_idx,
   output logic [DATA_W-1:0] o_second,
   output logic [IDX_W-1:0]  o_second_idx,
   output logic              o_sec_empty
);
   logic [CMP_W-1:0] w_score_x, w_best_x, w_second_x;
   logic             w_gt_best, w_gt_second;
   assign w_score_x   = SIGNED ? CMP_W'($signed(i_score))  : CMP_W'(i_score);
   assign w_best_x    = SIGNED ? CMP_W'($signed(i_best))   : CMP_W'(i_best);
   assign w_second_x  = SIGNED ? CMP_W'($signed(i_second)) : CMP_W'(i_second);
   // Strict greater-than keeps the lower index on ties
   assign w_gt_best   = score_gt(w_score_x, w_best_x, SIGNED);
   assign w_gt_second = i_sec_empty || score_gt(w_score_x, w_second_x, SIGNED);
   always_comb begin
      o_best       = i_best;
      o_best_idx   = i_best_idx;
      o_second     = i_second;
      o_second_idx = i_second_idx;
      o_sec_empty  = i_sec_empty;
      if (i_first) begin
         o_best       = i_score;
         o_best_idx   = i_idx;
         o_second     = '0;
         o_second_idx = '0;
         o_sec_empty  = 1'b1;
      end else if (w_gt_best) begin
         o_best       = i_score;
         o_best_idx   = i_idx;
         o_second     = i_best;
         o_second_idx = i_best_idx;
         o_sec_empty  = 1'b0;
      end else if (w_gt_second) begin
         o_second     = i_score;
         o_second_idx = i_idx;
         o_sec_empty  = 1'b0;
      end
   end
endmodule

// File: rtl/classifier_argmax_top2.sv
// classifier_argmax_top2: streaming top-2 argmax with margin, confidence and frame-length check
// Ports: clk/rst_n clock and async active-low reset; in_valid/in_ready/in_data/in_last score
//        stream; conf_thresh margin threshold; out_valid/out_ready result handshake;
//        out_best_idx/out_second_idx/out_best_val/out_margin/out_low_conf/out_frame_err result
module classifier_argmax_top2 import hwr_cls_pkg::*; #(
   parameter int N_CLASSES = N_CLASSES_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter bit SIGNED    = 1'b0,
   parameter int IDX_W     = $clog2(N_CLASSES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic [DATA_W-1:0] conf_thresh,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_best_idx,
   output logic [IDX_W-1:0]  out_second_idx,
   output logic [DATA_W-1:0] out_best_val,
   output logic [DATA_W-1:0] out_margin,
   output logic              out_low_conf,
   output logic              out_frame_err
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
   logic [IDX_W-1:0]  r_count, r_best_idx, r_second_idx;
   logic [DATA_W-1:0] r_best, r_second;
   logic              r_sec_empty;
   logic [IDX_W-1:0]  w_best_idx, w_second_idx;
   logic [DATA_W-1:0] w_best, w_second, w_margin;
   logic              w_sec_empty, w_accept, w_at_last, w_close;
   assign in_ready  = rst_n && (!out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_at_last = r_count == LAST_IDX;
   assign w_close   = w_at_last || in_last;
   // best >= second, so the low DATA_W bits of the difference are the exact unsigned margin
   assign w_margin  = w_sec_empty ? '0 : w_best - w_second;
   top2_tracker #(.DATA_W(DATA_W), .IDX_W(IDX_W), .SIGNED(SIGNED)) u_tracker (
      .i_score      (in_data),
      .i_idx        (r_count),
      .i_first      (r_count == '0),
      .i_best       (r_best),
      .i_best_idx   (r_best_idx),
      .i_second     (r_second),
      .i_second_idx (r_second_idx),
      .i_sec_empty  (r_sec_empty),
      .o_best       (w_best),
      .o_best_idx   (w_best_idx),
      .o_second     (w_second),
      .o_second_idx (w_second_idx),
      .o_sec_empty  (w_sec_empty)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count        <= '0;
         r_best         <= '0;
         r_best_idx     <= '0;
         r_second       <= '0;
         r_second_idx   <= '0;
         r_sec_empty    <= 1'b0;
         out_valid      <= 1'b0;
         out_best_idx   <= '0;
         out_second_idx <= '0;
         out_best_val   <= '0;
         out_margin     <= '0;
         out_low_conf   <= 1'b0;
         out_frame_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_count      <= w_close ? '0 : r_count + 1'b1;
            r_best       <= w_best;
            r_best_idx   <= w_best_idx;
            r_second     <= w_second;
            r_second_idx <= w_second_idx;
            r_sec_empty  <= w_sec_empty;
         end
         if (w_accept && w_close) begin
            out_valid      <= 1'b1;
            out_best_idx   <= w_best_idx;
            out_second_idx <= w_second_idx;
            out_best_val   <= w_best;
            out_margin     <= w_margin;
            out_low_conf   <= w_margin < conf_thresh;
            out_frame_err  <= in_last != w_at_last;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/classifier_argmax_top2.md
Name: classifier_argmax_top2

Overview:
- Streaming classifier back-end that accepts one class score per handshake and tracks the best and second-best scores with their class indices.
- At end of frame it emits the decision, the runner-up, the winning score, the winner-minus-runner-up margin, a low-confidence flag and a frame-error flag.
- Sits after the output-layer accumulator of the recognition pipeline.
- Parametrised in class count, score width and signedness, with valid/ready backpressure on both sides.

Parameters:
- N_CLASSES, 10, classes per frame (>=2).
- DATA_W, 12, score width in bits.
- SIGNED, 0, 1 = scores are two's complement; 0 = unsigned.
- IDX_W, $clog2(N_CLASSES), index width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  score valid
- in_ready  out  1  block can accept a score
- in_data  in  DATA_W  class score, class order 0..N_CLASSES-1
- in_last  in  1  marks the last score of a frame (checked, not trusted)
- conf_thresh  in  DATA_W  unsigned margin threshold, sampled at frame close
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts result
- out_best_idx  out  IDX_W  decision
- out_second_idx  out  IDX_W  runner-up class
- out_best_val  out  DATA_W  winning score
- out_margin  out  DATA_W  best minus second, unsigned
- out_low_conf  out  1  out_margin < conf_thresh
- out_frame_err  out  1  in_last mismatched the class count

Behaviour:
- Reset: all outputs 0 and in_ready 0 during reset. Internal count, best/second values and indices are cleared. Mid-frame reset discards the partial frame, including any held result.
- Accept: a score is taken when in_valid && in_ready. in_ready = !out_valid || out_ready, so a result being accepted and a new score can be taken in the same cycle.
- Compare: signed when SIGNED=1, otherwise unsigned. Strict greater-than, so on ties the lower index wins for both best and second.
- Element 0: initialises best = in_data and best_idx = 0. Second is marked empty. There is no zero-initialised comparison, so all-negative frames decide correctly.
- Element k>0, score > best: second <= best, best <= score.
- Element k>0, score > second or second empty: second <= score.
- Otherwise: best and second are unchanged.
- Frame close occurs on the accepted element where count == N_CLASSES-1 or in_last == 1, whichever comes first.
  - out_frame_err = 1 if in_last differs from (count == N_CLASSES-1).
  - A short frame (in_last early) closes with err = 1.
  - A long frame (count reaches N-1 without in_last) closes with err = 1. The following scores start a new frame.
  - The closing element is included in the comparison.
- Close latency: results are registered in the cycle after the closing handshake, so out_valid rises 1 cycle after the last element is accepted.
  - Registered results: best/second including the closing element, out_margin = best - second computed in DATA_W+1 bits and truncated to DATA_W (always fits), out_low_conf.
  - Count and trackers re-arm in the same edge, so the next frame's element 0 may be accepted in the very next cycle.
- One-element frame (in_last on element 0): second_idx = 0, margin = 0, low_conf = (conf_thresh != 0), err = 1.
- Output hold: out_* stay stable while out_valid && !out_ready. out_valid drops on the accept edge unless a new frame closes on that same edge.
- Counter wrap: count is IDX_W bits and never exceeds N_CLASSES-1.

Decomposition:
- Shared package hwr_cls_pkg:
  - score_gt(a, b, signed_mode) compare function
  - localparam defaults N_CLASSES_DEF = 10 and DATA_W_DEF = 12
  - typedef for the result struct (best_idx, second_idx, best_val, margin, low_conf, frame_err)
- Sub-module top2_tracker (combinational next-state of best/second values and indices, given the incoming score, its index and the first/empty flags).
- Handshake, counter and frame-close logic live in the top level.

Test Plan:
- Defaults, unsigned, scores 5,9,3,9,1,0,2,8,7,4 with in_last on the 10th -> best_idx=1, second_idx=3, best_val=9, margin=0, low_conf=1 with thresh=1, err=0.
- SIGNED=1, all-negative frame -100,-7,-50,...,-7 at idx 9 -> best_idx=1, best_val=-7 (0xFF9), margin=0, err=0.
- in_last asserted on the 4th score (scores 10,40,20,30) -> out_valid 1 cycle later, best_idx=1, second_idx=3, margin=10, err=1; the next score starts a fresh frame.
- 10 scores with no in_last -> result at count 9, err=1. A 1-element frame with in_last -> second_idx=0, margin=0, err=1.
- Hold out_ready=0 for 20 cycles after a result -> outputs stable, in_ready=0, no score lost. Then assert out_ready together with in_valid -> both handshakes complete in the same cycle.
- Assert rst_n=0 after 5 scores -> all outputs 0. The next 10-score frame decides as if the partial frame never occurred.
